// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle CPU: the multiply/divide
// sequencer states, its iteration count and the MULT/DIV request decode.
package mips_pkg;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } mdState_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_MULT = 2'b01,
        OP_DIV  = 2'b10
    } mdOp_t;

    // A multiply request takes priority when both starts arrive together.
    function automatic mdOp_t mdDecode(input logic startMult, input logic startDiv);
        mdOp_t op;
        op = OP_NONE;
        if (startMult) begin
            op = OP_MULT;
        end else if (startDiv) begin
            op = OP_DIV;
        end
        return op;
    endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the main control FSM (master) and the
// multiply/divide sequencer (slave).
interface mult_div_ctrl_if #(parameter int WIDTH = 32);

    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             hi_lo_write;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, start_div, op_a, op_b,
        input  busy, done, hi_lo_write, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b,
        output busy, done, hi_lo_write, div_zero, hi, lo
    );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-divide iteration on unsigned magnitudes: shift {rem, quo}
// left by one, trial-subtract the divisor and keep the difference if it
// did not go negative.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    // remShift < 2*divisor, so the difference fits a WIDTH+1 bit signed value
    // and its top bit is the borrow.
    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;

    // Shift, trial-subtract and restore on borrow.
    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        diff     = remShift - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            remNext = diff[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end else begin
            remNext = remShift[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle signed multiply/divide sequencer behind HI/LO. One start pulse
// launches a 32-step radix-2 Booth multiply or restoring divide; the result
// is written to HI/LO once, on the edge that enters DONE.
module mult_div_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = MD_ITERS   // must equal WIDTH
) (
    input  logic clk,
    input  logic reset,
    mult_div_ctrl_if.slave md
);

    localparam int              CNT_W     = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    mdState_t         state;
    logic [CNT_W-1:0] iterCount;

    logic             busyReg;
    logic             doneReg;
    logic             hiLoWriteReg;
    logic             divZeroReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;

    // Booth state. The accumulator carries one guard bit so that adding or
    // subtracting a most-negative multiplicand never overflows mid-sequence.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             qMinus1;
    logic [WIDTH-1:0] multiplicand;

    // Divide state, all on magnitudes; signs are reapplied at the end.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             quoNeg;
    logic             remNeg;

    logic [WIDTH:0]   mcandExt;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   accNext;
    logic [WIDTH-1:0] qNext;
    logic             qMinus1Next;

    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoFixed;
    logic [WIDTH-1:0] remFixed;

    // |0x80000000| wraps back to 0x80000000, which read unsigned is 2^31.
    logic [WIDTH-1:0] opAMag;
    logic [WIDTH-1:0] opBMag;

    mdOp_t            reqOp;

    assign reqOp  = mdDecode(md.start_mult, md.start_div);
    assign opAMag = md.op_a[WIDTH-1] ? -md.op_a : md.op_a;
    assign opBMag = md.op_b[WIDTH-1] ? -md.op_b : md.op_b;

    // One Booth step: add/subtract the multiplicand per {q0, q-1}, then
    // arithmetic shift {acc, q, q-1} right by one.
    always_comb begin
        // NOTE: every always_comb output gets a value before any branch, so no
        // path can leave it holding its old value and infer a latch.
        mcandExt = {multiplicand[WIDTH-1], multiplicand};
        boothSum = acc;
        case ({q[0], qMinus1})
            2'b01:   boothSum = acc + mcandExt;
            2'b10:   boothSum = acc - mcandExt;
            default: boothSum = acc;
        endcase
        accNext     = {boothSum[WIDTH], boothSum[WIDTH:1]};
        qNext       = {boothSum[0], q[WIDTH-1:1]};
        qMinus1Next = q[0];
    end

    div_restore_step #(.WIDTH(WIDTH)) uDivStep (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .remNext (remNext),
        .quoNext (quoNext)
    );

    // Sign fix: quotient negative when operand signs differ, remainder
    // follows the dividend.
    assign quoFixed = quoNeg ? -quoNext : quoNext;
    assign remFixed = remNeg ? -remNext : remNext;

    // Sequencer FSM with registered outputs; DONE lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples the pre-edge values, independent of order.
            state        <= IDLE;
            iterCount    <= '0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            hiLoWriteReg <= 1'b0;
            divZeroReg   <= 1'b0;
            hiReg        <= '0;
            loReg        <= '0;
            acc          <= '0;
            q            <= '0;
            qMinus1      <= 1'b0;
            multiplicand <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            quoNeg       <= 1'b0;
            remNeg       <= 1'b0;
        end else begin
            doneReg      <= 1'b0;
            hiLoWriteReg <= 1'b0;
            divZeroReg   <= 1'b0;

            case (state)
                IDLE: begin
                    case (reqOp)
                        OP_MULT: begin
                            state        <= MULT;
                            busyReg      <= 1'b1;
                            iterCount    <= '0;
                            acc          <= '0;
                            q            <= md.op_b;
                            qMinus1      <= 1'b0;
                            multiplicand <= md.op_a;
                        end
                        OP_DIV: begin
                            busyReg   <= 1'b1;
                            iterCount <= '0;
                            if (md.op_b == '0) begin
                                state      <= DONE;
                                doneReg    <= 1'b1;
                                divZeroReg <= 1'b1;
                            end else begin
                                state   <= DIV;
                                rem     <= '0;
                                quo     <= opAMag;
                                divisor <= opBMag;
                                quoNeg  <= md.op_a[WIDTH-1] ^ md.op_b[WIDTH-1];
                                remNeg  <= md.op_a[WIDTH-1];
                            end
                        end
                        default: ;
                    endcase
                end

                MULT: begin
                    acc       <= accNext;
                    q         <= qNext;
                    qMinus1   <= qMinus1Next;
                    iterCount <= iterCount + CNT_W'(1);
                    if (iterCount == LAST_ITER) begin
                        state        <= DONE;
                        hiReg        <= accNext[WIDTH-1:0];
                        loReg        <= qNext;
                        doneReg      <= 1'b1;
                        hiLoWriteReg <= 1'b1;
                    end
                end

                DIV: begin
                    rem       <= remNext;
                    quo       <= quoNext;
                    iterCount <= iterCount + CNT_W'(1);
                    if (iterCount == LAST_ITER) begin
                        state        <= DONE;
                        hiReg        <= remFixed;
                        loReg        <= quoFixed;
                        doneReg      <= 1'b1;
                        hiLoWriteReg <= 1'b1;
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy        = busyReg;
    assign md.done        = doneReg;
    assign md.hi_lo_write = hiLoWriteReg;
    assign md.div_zero    = divZeroReg;
    assign md.hi          = hiReg;
    assign md.lo          = loReg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: inputs change and outputs are sampled on
// the falling edge, away from the active rising edge.
module tb_mult_div_ctrl;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Result of the most recent runOp.
    int          lat;
    logic        rHlw;
    logic        rDz;
    logic [31:0] rHi;
    logic [31:0] rLo;
    logic        rBusyAfter;

    mult_div_ctrl_if #(.WIDTH(32)) mdIf ();

    mult_div_ctrl #(.WIDTH(32), .ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Issue one start, scramble the operands afterwards, then wait for done.
    // lat counts falling edges after the start edge; -1 means it never came.
    task automatic runOp(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdIf.start_mult = sm;
        mdIf.start_div  = sd;
        mdIf.op_a       = a;
        mdIf.op_b       = b;
        @(negedge clk);
        mdIf.start_mult = 1'b0;
        mdIf.start_div  = 1'b0;
        mdIf.op_a       = 32'hDEADBEEF;
        mdIf.op_b       = 32'h0BADF00D;
        lat = 0;
        while (mdIf.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) lat = -1;
        rHlw = mdIf.hi_lo_write;
        rDz  = mdIf.div_zero;
        rHi  = mdIf.hi;
        rLo  = mdIf.lo;
        @(negedge clk);
        rBusyAfter = mdIf.busy;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        mdIf.start_mult = 1'b0;
        mdIf.start_div  = 1'b0;
        mdIf.op_a       = '0;
        mdIf.op_b       = '0;
        repeat (2) @(negedge clk);
        mdIf.start_mult = 1'b1;
        mdIf.op_a       = 32'd3;
        mdIf.op_b       = 32'd3;
        @(negedge clk);
        checks++;
        if ({mdIf.busy, mdIf.done, mdIf.hi_lo_write, mdIf.div_zero} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {mdIf.busy, mdIf.done, mdIf.hi_lo_write, mdIf.div_zero});
        end
        checks++;
        if ({mdIf.hi, mdIf.lo} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo got %h_%h want 0_0", mdIf.hi, mdIf.lo);
        end
        mdIf.start_mult = 1'b0;
        reset           = 1'b1;
        @(negedge clk);
        checks++;
        if (mdIf.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored busy got %b want 0", mdIf.busy);
        end
    endtask

    task automatic test_mult();
        logic [31:0] a  [3];
        logic [31:0] b  [3];
        logic [31:0] eh [3];
        logic [31:0] el [3];
        a  = '{32'h00000007, 32'h7FFFFFFF, 32'h80000000};
        b  = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000000};
        eh = '{32'hFFFFFFFF, 32'h3FFFFFFF, 32'h40000000};
        el = '{32'hFFFFFFEB, 32'h00000001, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            runOp(1'b1, 1'b0, a[i], b[i]);
            checks++;
            if (lat !== 32 || rHlw !== 1'b1 || rDz !== 1'b0) begin
                errors++;
                $display("FAIL mult%0d_timing lat %0d hlw %b dz %b want 32 1 0", i, lat, rHlw, rDz);
            end
            checks++;
            if (rHi !== eh[i]) begin
                errors++;
                $display("FAIL mult%0d_hi got %h want %h", i, rHi, eh[i]);
            end
            checks++;
            if (rLo !== el[i]) begin
                errors++;
                $display("FAIL mult%0d_lo got %h want %h", i, rLo, el[i]);
            end
            checks++;
            if (rBusyAfter !== 1'b0) begin
                errors++;
                $display("FAIL mult%0d_idle busy got %b want 0", i, rBusyAfter);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] a  [3];
        logic [31:0] b  [3];
        logic [31:0] eh [3];
        logic [31:0] el [3];
        a  = '{32'hFFFFFFF9, 32'h80000000, 32'h00000007};
        b  = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        eh = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        el = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD};
        for (int i = 0; i < 3; i++) begin
            runOp(1'b0, 1'b1, a[i], b[i]);
            checks++;
            if (lat !== 32 || rHlw !== 1'b1 || rDz !== 1'b0) begin
                errors++;
                $display("FAIL div%0d_timing lat %0d hlw %b dz %b want 32 1 0", i, lat, rHlw, rDz);
            end
            checks++;
            if (rHi !== eh[i]) begin
                errors++;
                $display("FAIL div%0d_hi got %h want %h", i, rHi, eh[i]);
            end
            checks++;
            if (rLo !== el[i]) begin
                errors++;
                $display("FAIL div%0d_lo got %h want %h", i, rLo, el[i]);
            end
        end
    endtask

    // Runs right after 7 / -2, so HI/LO must still read 1 / 0xFFFFFFFD.
    task automatic test_div_zero();
        runOp(1'b0, 1'b1, 32'd10, 32'd0);
        checks++;
        if (lat !== 0 || rDz !== 1'b1 || rHlw !== 1'b0) begin
            errors++;
            $display("FAIL divzero_flags lat %0d dz %b hlw %b want 0 1 0", lat, rDz, rHlw);
        end
        checks++;
        if (rHi !== 32'h00000001 || rLo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL divzero_hold got %h_%h want 00000001_fffffffd", rHi, rLo);
        end
        checks++;
        if (rBusyAfter !== 1'b0) begin
            errors++;
            $display("FAIL divzero_idle busy got %b want 0", rBusyAfter);
        end
    endtask

    // 5 * 6 = 30 from the multiply; a divide would give lo=0, hi=5.
    task automatic test_both_start();
        runOp(1'b1, 1'b1, 32'd5, 32'd6);
        checks++;
        if (lat !== 32 || rHi !== 32'd0 || rLo !== 32'd30) begin
            errors++;
            $display("FAIL both_start lat %0d hilo %h_%h want 32 00000000_0000001e", lat, rHi, rLo);
        end
    endtask

    task automatic test_reset_mid();
        int doneCount;
        @(negedge clk);
        mdIf.start_mult = 1'b1;
        mdIf.op_a       = 32'd3;
        mdIf.op_b       = 32'd4;
        @(negedge clk);
        mdIf.start_mult = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (mdIf.busy !== 1'b0 || mdIf.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flags busy %b done %b want 0 0", mdIf.busy, mdIf.done);
        end
        checks++;
        if (mdIf.hi !== 32'd0 || mdIf.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_hilo got %h_%h want 0_0", mdIf.hi, mdIf.lo);
        end
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdIf.done === 1'b1) doneCount++;
        end
        checks++;
        if (doneCount !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_resume done count %0d want 0", doneCount);
        end
    endtask

    task automatic test_busy_ignore();
        int doneCount;
        logic [31:0] lastLo;
        doneCount = 0;
        lastLo    = 32'hX;
        @(negedge clk);
        mdIf.start_mult = 1'b1;
        mdIf.op_a       = 32'd2;
        mdIf.op_b       = 32'd3;
        @(negedge clk);
        mdIf.start_mult = 1'b0;
        repeat (5) @(negedge clk);
        mdIf.start_div = 1'b1;
        mdIf.op_a      = 32'd100;
        mdIf.op_b      = 32'd1;
        @(negedge clk);
        mdIf.start_div = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (mdIf.done === 1'b1) begin
                doneCount++;
                lastLo = mdIf.lo;
            end
        end
        checks++;
        if (doneCount !== 1) begin
            errors++;
            $display("FAIL busy_ignore_count done count %0d want 1", doneCount);
        end
        checks++;
        if (lastLo !== 32'd6) begin
            errors++;
            $display("FAIL busy_ignore_result lo got %h want 00000006", lastLo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_both_start();
        test_reset_mid();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
